// File: rtl/bcd_digit_scan_if.sv
// Purpose : bundles the display scanner's load inputs and display outputs.
// Ports   : digits_in/load (toward scanner), bcd/an/frame_sync (from scanner).
// Modports: master = producer of digits / consumer of drive signals, slave = scanner.
interface bcd_digit_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic [3:0]              bcd;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_sync;

    modport master (
        output digits_in,
        output load,
        input  bcd,
        input  an,
        input  frame_sync
    );

    modport slave (
        input  digits_in,
        input  load,
        output bcd,
        output an,
        output frame_sync
    );
endinterface

// File: rtl/bcd_digit_scan.sv
// Purpose : time-multiplexed common-anode 7-segment scanner with tear-free
//           frame snapshot, leading-zero blanking and anti-ghosting dead time.
// Ports   : clk, rst_n (async active-low); bus.slave carries digits_in/load in,
//           bcd (4'hF = blank), an (active-low, at most one low), frame_sync out.
// Latency : outputs registered, one cycle behind the prescaler/index state.
module bcd_digit_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 2,
    parameter int LZ_BLANK    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_digit_scan_if.slave  bus
);
    localparam int CNTW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDXW = $clog2(NUM_DIGITS);
    localparam int DW   = 4 * NUM_DIGITS;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(REFRESH_DIV - 1);
    localparam logic [CNTW-1:0] CNT_DEAD = CNTW'(DEAD_CYC);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_DIGITS - 1);

    logic [CNTW-1:0]       r_cnt;
    logic [IDXW-1:0]       r_idx;
    logic [DW-1:0]         r_shadow;
    logic [DW-1:0]         r_active;
    logic                  r_pend;
    logic [3:0]            r_bcd;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_sync;

    logic                  w_slot_end;
    logic                  w_wrap;
    logic                  w_live;
    logic                  w_upper_zero;
    logic                  w_blank;
    logic [3:0]            w_nib;
    logic [3:0]            w_bcd_nxt;
    logic [NUM_DIGITS-1:0] w_an_nxt;

    assign w_slot_end = (r_cnt == CNT_LAST);
    assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);
    // Anodes stay off for the first DEAD_CYC clocks of each slot so the
    // previous digit's segments never light the next anode.
    assign w_live     = (r_cnt >= CNT_DEAD);

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDXW'(1);
        end else begin
            r_cnt <= r_cnt + CNTW'(1);
        end
    end

    // Snapshot path: loads park in the shadow and only reach the displayed
    // copy at a frame wrap, so one frame never shows a mix of old and new.
    // A load landing exactly on the wrap goes straight through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_active <= '0;
            r_pend   <= 1'b0;
        end else if (bus.load) begin
            r_shadow <= bus.digits_in;
            if (w_wrap) begin
                r_active <= bus.digits_in;
                r_pend   <= 1'b0;
            end else begin
                r_pend   <= 1'b1;
            end
        end else if (w_wrap && r_pend) begin
            r_active <= r_shadow;
            r_pend   <= 1'b0;
        end
    end

    // Select the current nibble, detect "this and all higher digits are
    // zero" for leading-zero blanking, and build the anode pattern.
    always_comb begin
        w_upper_zero = 1'b1;
        w_nib        = 4'hF;
        w_an_nxt     = '1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= int'(r_idx)) && (r_active[4*j +: 4] != 4'h0)) begin
                w_upper_zero = 1'b0;
            end
            if (j == int'(r_idx)) begin
                w_nib = r_active[4*j +: 4];
                if (w_live) begin
                    w_an_nxt[j] = 1'b0;
                end
            end
        end
        // Digit 0 is never blanked so an all-zero value still shows "0".
        w_blank   = (LZ_BLANK != 0) && (r_idx != '0) && w_upper_zero;
        w_bcd_nxt = (w_live && !w_blank) ? w_nib : 4'hF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd        <= 4'hF;
            r_an         <= '1;
            r_frame_sync <= 1'b0;
        end else begin
            r_bcd        <= w_bcd_nxt;
            r_an         <= w_an_nxt;
            r_frame_sync <= w_wrap;
        end
    end

    assign bus.bcd        = r_bcd;
    assign bus.an         = r_an;
    assign bus.frame_sync = r_frame_sync;
endmodule

// File: tb/tb_bcd_digit_scan.sv
module tb_bcd_digit_scan;
    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int DEAD  = 1;
    localparam int FRAME = N * RD;

    logic clk;
    logic rst_n;
    int   n;          // edges processed since reset release (model time)
    int   checks;
    int   errors;
    logic [15:0] m_latest;
    logic [15:0] m_frame;

    bcd_digit_scan_if #(.NUM_DIGITS(N)) bus ();

    bcd_digit_scan #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(RD),
        .DEAD_CYC   (DEAD),
        .LZ_BLANK   (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t n=%0d)", name, got, exp, $time, n);
        end
    endtask

    // Model: position n in the scan gives slot = n/RD mod N, phase = n mod RD.
    // A frame shows the most recent value loaded at or before the last edge
    // of the previous frame.
    always @(posedge clk) begin
        logic [3:0]  e_an;
        logic [3:0]  e_bcd;
        logic        e_fs;
        logic [15:0] upper;
        int          pos;
        int          slot;
        int          ph;
        if (!rst_n) begin
            n        = 0;
            m_latest = 16'h0;
            m_frame  = 16'h0;
            e_an     = 4'hF;
            e_bcd    = 4'hF;
            e_fs     = 1'b0;
        end else begin
            pos   = n % FRAME;
            slot  = pos / RD;
            ph    = n % RD;
            e_an  = 4'hF;
            if (ph >= DEAD) e_an[slot] = 1'b0;
            upper = m_frame >> (4 * slot);
            if (ph < DEAD || (slot > 0 && upper == 16'h0)) e_bcd = 4'hF;
            else                                            e_bcd = upper[3:0];
            e_fs  = (pos == FRAME - 1);
            if (bus.load) m_latest = bus.digits_in;
            if (e_fs)     m_frame  = m_latest;
            n++;
        end
        #1;
        chk("an", 32'(bus.an), 32'(e_an));
        chk("bcd", 32'(bus.bcd), 32'(e_bcd));
        chk("frame_sync", 32'(bus.frame_sync), 32'(e_fs));
        chk("an_at_most_one_low", 32'($countones(~bus.an) <= 1), 32'd1);
    end

    task automatic goto(input int target);
        int k;
        k = 0;
        while (n != target && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (n != target) begin
            checks++;
            errors++;
            $display("FAIL goto: reached %0d expected %0d", n, target);
        end
    endtask

    task automatic pulse(input logic [15:0] val);
        bus.digits_in = val;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.load      = 1'b0;
    endtask

    task automatic lit(input string name, input logic [3:0] e_an, input logic [3:0] e_bcd);
        chk({name, "_an"}, 32'(bus.an), 32'(e_an));
        chk({name, "_bcd"}, 32'(bus.bcd), 32'(e_bcd));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        n             = 0;
        bus.digits_in = 16'h0;
        bus.load      = 1'b0;
        rst_n         = 1'b1;
        #1 rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        lit("reset", 4'hF, 4'hF);
        chk("reset_fs", 32'(bus.frame_sync), 32'd0);
        rst_n = 1'b1;

        // 1: blank scan of zeros
        goto(1);  lit("s1_pos0", 4'hF, 4'hF);
        goto(2);  lit("s1_pos1", 4'hE, 4'h0);
        goto(6);  lit("s1_pos5", 4'hD, 4'hF);
        goto(16); chk("s1_fs_pos15", 32'(bus.frame_sync), 32'd1);
        goto(17); chk("s1_fs_pos16", 32'(bus.frame_sync), 32'd0);

        // 2: mid-frame load shows only from the next frame
        goto(20); pulse(16'h1234);
        goto(22); lit("s2_old_frame", 4'hD, 4'hF);
        goto(34); lit("s2_d0", 4'hE, 4'h4);
        goto(46); lit("s2_d3", 4'h7, 4'h1);

        // 3: leading-zero blanking
        goto(50); pulse(16'h0070);
        goto(70); lit("s3_d1", 4'hD, 4'h7);
        goto(74); lit("s3_d2", 4'hB, 4'hF);
        goto(80); pulse(16'h0000);
        goto(98);  lit("s3_zero_d0", 4'hE, 4'h0);
        goto(102); lit("s3_zero_d1", 4'hD, 4'hF);

        // 4: load in the wrap cycle bypasses; repeated loads, last wins
        goto(111); pulse(16'h5678);
        goto(114); lit("s4_bypass_d0", 4'hE, 4'h8);
        goto(126); lit("s4_bypass_d3", 4'h7, 4'h5);
        goto(130); pulse(16'h1111);
        goto(134); lit("s4_hold_d1", 4'hD, 4'h7);
        goto(135); pulse(16'h2222);
        goto(150); lit("s4_last_wins", 4'hD, 4'h2);

        // 5: async reset mid-slot-2
        goto(171); lit("s5_pre_reset", 4'hB, 4'h2);
        #2 rst_n = 1'b0;
        #1 lit("s5_async_reset", 4'hF, 4'hF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        goto(2); lit("s5_restart_d0", 4'hE, 4'h0);
        goto(6); lit("s5_restart_d1", 4'hD, 4'hF);

        // 6: non-decimal nibble passes through
        goto(10); pulse(16'h00A3);
        goto(18); lit("s6_d0", 4'hE, 4'h3);
        goto(22); lit("s6_d1_hex", 4'hD, 4'hA);
        goto(26); lit("s6_d2_blank", 4'hB, 4'hF);
        goto(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
